// File: rtl/mux_nch_pkg.sv
// mux_nch_reg shared package: mode constants and index helpers.
// Used by the mux, its interface and the round-robin arbiter.
package mux_nch_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(
    input int k,
    input int n
  );
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/mux_nch_reg_if.sv
// mux_nch_reg port bundle: N producer streams in, one registered stream out.
// slave = the mux, master = the producers/consumer driving it.
interface mux_nch_reg_if
  import mux_nch_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);

  localparam int SELW = sel_w(N);

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic            mode;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] grant;

  modport slave (
    input  in_data,
    input  in_valid,
    input  sel,
    input  mode,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output grant
  );

  modport master (
    output in_data,
    output in_valid,
    output sel,
    output mode,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  grant
  );

endinterface

// File: rtl/mux_nch_reg_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Only instantiated when MUX_NCH_RR_EN is defined.
module rr_arbiter
  import mux_nch_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = sel_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] winner,
  output logic            any_req
);

  int              idx;
  logic [SELW-1:0] idx_s;

  // Scan farthest-first so the nearest requester overwrites last.
  always_comb begin
    winner = '0;
    idx    = 0;
    idx_s  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      idx_s = SELW'(idx);
      if (req[idx_s]) winner = idx_s;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux_nch_reg.sv
// N-channel registered mux with valid/ready on every port.
// MUX_NCH_RR_EN: enables round-robin mode (else fixed-select only).
module mux_nch_reg
  import mux_nch_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic          clk,
  input logic          rst_n,
  mux_nch_reg_if.slave bus
);

  localparam int SELW = sel_w(N);

  logic [W-1:0]    ch [N];
  logic [W-1:0]    data_q;
  logic [SELW-1:0] grant_q;
  logic [SELW-1:0] pick;
  logic [N-1:0]    ready;
  logic            valid_q;
  logic            can_accept;
  logic            pick_ok;
  logic            sel_ok;
  logic            xfer;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = bus.in_data[k*W +: W];
  end

  assign can_accept = !valid_q || bus.out_ready;
  assign sel_ok     = int'(bus.sel) < N;

`ifdef MUX_NCH_RR_EN
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] rr_win;
  logic            rr_any;

  rr_arbiter #(.N(N)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .winner  (rr_win),
    .any_req (rr_any)
  );

  always_comb begin
    pick    = bus.sel;
    pick_ok = sel_ok;
    if (bus.mode == MODE_RR) begin
      pick    = rr_win;
      pick_ok = rr_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (xfer && bus.mode == MODE_RR) begin
      ptr_q <= SELW'(wrap_inc(int'(pick), N));
    end
  end
`else
  logic mode_unused;

  assign mode_unused = bus.mode;
  assign pick        = bus.sel;
  assign pick_ok     = sel_ok;
`endif

  // Fixed mode offers ready regardless of in_valid.
  always_comb begin
    ready = '0;
    if (pick_ok && can_accept) ready[pick] = 1'b1;
  end

  assign xfer = |(ready & bus.in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= ch[pick];
      grant_q <= pick;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mux_nch_reg.sv
// Bench for mux_nch_reg (N=4, W=8): directed steps plus random traffic
// against a queue-free reference model of the arbitration rules.
module tb_mux_nch_reg;

  localparam int N = 4;
  localparam int W = 8;
`ifdef MUX_NCH_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mux_nch_reg_if #(.N(N), .W(W)) bus ();

  mux_nch_reg #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_grant;
  int           m_ptr;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int           k;
    r = '0;
    k = 0;
    if (m_valid && !bus.out_ready) return r;
    if (RR && bus.mode) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (bus.in_valid[k]) begin
          r[k] = 1'b1;
          return r;
        end
      end
    end else if (int'(bus.sel) < N) begin
      r[bus.sel] = 1'b1;
    end
    return r;
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_grant = 0;
    m_ptr   = 0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".ov"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".od"}, 32'(bus.out_data), 32'(m_data));
    chk({tag, ".gr"}, 32'(bus.grant), 32'(m_grant));
  endtask

  // Entered at a negedge with inputs set; leaves at the next negedge.
  task automatic cycle(input string tag);
    logic [N-1:0] r;
    int           k;
    r = m_ready();
    #1 chk({tag, ".rdy"}, 32'(bus.in_ready), 32'(r));
    @(posedge clk);
    k = -1;
    for (int i = 0; i < N; i++)
      if (r[i] && bus.in_valid[i]) k = i;
    if (k >= 0) begin
      m_valid = 1'b1;
      m_data  = bus.in_data[k*W +: W];
      m_grant = k;
      if (RR && bus.mode) m_ptr = (k + 1) % N;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1 chk_out(tag);
    @(negedge clk);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.sel       = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    m_reset();

    #1 chk_out("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    bus.mode      = 1'b0;
    bus.sel       = 2'd2;
    bus.in_data   = 32'h00A5_0000;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    cycle("fx_a5");
    chk("fx_a5.data", 32'(bus.out_data), 32'h0000_00A5);
    chk("fx_a5.gnt", 32'(bus.grant), 32'd2);

    bus.in_data  = 32'h0000_7700;
    bus.in_valid = 4'b0010;
    cycle("fx_nosel");
    chk("fx_nosel.ov", 32'(bus.out_valid), 32'd0);

    bus.in_data  = 32'h00A5_0000;
    bus.in_valid = 4'b0100;
    cycle("fx_re");

    bus.out_ready = 1'b0;
    bus.in_data   = 32'h0011_0000;
    for (int i = 0; i < 5; i++) begin
      cycle("bp");
      chk("bp.rdy0", 32'(bus.in_ready), 32'd0);
      chk("bp.hold", 32'(bus.out_data), 32'h0000_00A5);
    end

    bus.out_ready = 1'b1;
    bus.in_data   = 32'h003C_0000;
    cycle("hand");
    chk("hand.data", 32'(bus.out_data), 32'h0000_003C);
    chk("hand.ov", 32'(bus.out_valid), 32'd1);

    bus.out_ready = 1'b0;
    bus.in_data   = 32'h0099_0000;
    cycle("stall");
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk_out("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'h4433_2211;
    bus.mode      = 1'b1;
    bus.sel       = 2'd1;
`ifdef MUX_NCH_RR_EN
    for (int i = 0; i < 6; i++) begin
      cycle("rr_all");
      chk("rr_all.seq", 32'(bus.grant), 32'(i % N));
    end
    bus.in_valid = 4'b1010;
    cycle("rr_skip");
    chk("rr_skip.g3", 32'(bus.grant), 32'd3);
    cycle("rr_wrap");
    chk("rr_wrap.g1", 32'(bus.grant), 32'd1);
    bus.in_valid = 4'b1111;
    cycle("rr_ptr2");
    chk("rr_ptr2.g2", 32'(bus.grant), 32'd2);
`else
    for (int i = 0; i < 4; i++) begin
      cycle("nomode");
      chk("nomode.g1", 32'(bus.grant), 32'd1);
    end
`endif

    for (int i = 0; i < 300; i++) begin
      bus.in_data   = $urandom;
      bus.in_valid  = 4'($urandom);
      bus.sel       = 2'($urandom);
      bus.mode      = 1'($urandom);
      bus.out_ready = ($urandom % 4) != 0;
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
